// File: rtl/lcd_pkg.sv
// Shared command codes, decoder state encoding and pixel type for the
// 8080-style display bus receiver.
package lcd_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPIN   = 8'h10;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET_P,
        ST_PASET_P,
        ST_RAMWR_HI,
        ST_RAMWR_LO,
        ST_SKIP
    } lcd_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // The bus carries the high byte of each pixel first.
    function automatic rgb565_t to_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/lcd_bus_decoder_if.sv
// Raw 8080-style write bus: data/command select, write strobe and byte.
interface lcd_bus_decoder_if;

    logic       dcx;
    logic       wr;
    logic [7:0] D;

    modport master (output dcx, output wr, output D);
    modport slave  (input  dcx, input  wr, input  D);

endinterface

// File: rtl/lcd_addr_counter.sv
// Column/page window registers and the current write address, with
// window-wrapping advance.
module lcd_addr_counter #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       load_col,
    input  logic       load_page,
    input  logic       restore,
    input  logic [8:0] win_start,
    input  logic [8:0] win_end,
    input  logic       start,
    input  logic       advance,
    output logic [8:0] x,
    output logic [8:0] y
);

    localparam logic [8:0] X_MAX = 9'(WIDTH - 1);
    localparam logic [8:0] Y_MAX = 9'(HEIGHT - 1);

    logic [8:0] sc, ec, sp, ep;
    logic       col_wrap, page_wrap;

    // The panel edge also wraps, so an inverted window (start > end) still terminates.
    assign col_wrap  = (x == ec) || (x == X_MAX);
    assign page_wrap = (y == ep) || (y == Y_MAX);

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            sc <= '0;
            ec <= X_MAX;
            sp <= '0;
            ep <= Y_MAX;
            x  <= '0;
            y  <= '0;
        end else begin
            if (restore) begin
                sc <= '0;
                ec <= X_MAX;
                sp <= '0;
                ep <= Y_MAX;
            end
            if (load_col) begin
                sc <= win_start;
                ec <= win_end;
            end
            if (load_page) begin
                sp <= win_start;
                ep <= win_end;
            end
            if (start) begin
                x <= sc;
                y <= sp;
            end else if (advance) begin
                if (col_wrap) begin
                    x <= sc;
                    y <= page_wrap ? sp : y + 9'd1;
                end else begin
                    x <= x + 9'd1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_bus_decoder.sv
// Samples the 8080 bus in the hwclk domain and decodes command, window
// parameter and RGB565 pixel traffic into per-pixel pulses.
module lcd_bus_decoder
    import lcd_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic               hwclk,
    input  logic               rst,
    lcd_bus_decoder_if.slave   bus,
    output logic               cmd_valid,
    output logic [7:0]         cmd_code,
    output logic               pix_valid,
    output logic [8:0]         pix_x,
    output logic [8:0]         pix_y,
    output rgb565_t            pix_data,
    output logic               disp_on,
    output logic               sleep_out
);

    logic       wr_s1, wr_s2, wr_s3, dcx_s1, dcx_s2;
    logic [7:0] d_s1, d_s2;
    logic       stb, stb_dcx;
    logic [7:0] stb_byte;

    // NOTE: dcx and D go through the same two flops as wr so the byte lines up with its strobe.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            wr_s1    <= 1'b0;
            wr_s2    <= 1'b0;
            wr_s3    <= 1'b0;
            dcx_s1   <= 1'b0;
            dcx_s2   <= 1'b0;
            d_s1     <= '0;
            d_s2     <= '0;
            stb      <= 1'b0;
            stb_dcx  <= 1'b0;
            stb_byte <= '0;
        end else begin
            wr_s1    <= bus.wr;
            wr_s2    <= wr_s1;
            wr_s3    <= wr_s2;
            dcx_s1   <= bus.dcx;
            dcx_s2   <= dcx_s1;
            d_s1     <= bus.D;
            d_s2     <= d_s1;
            stb      <= wr_s2 & ~wr_s3;
            stb_dcx  <= dcx_s2;
            stb_byte <= d_s2;
        end
    end

    logic       cmd_stb, dat_stb;
    lcd_state_e state;
    logic [2:0] idx;
    logic       p0_lsb, p2_lsb;
    logic [7:0] p1, hi_byte;
    logic [8:0] x, y;

    assign cmd_stb = stb & ~stb_dcx;
    assign dat_stb = stb &  stb_dcx;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            p0_lsb    <= 1'b0;
            p1        <= '0;
            p2_lsb    <= 1'b0;
            hi_byte   <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_data  <= '0;
            disp_on   <= 1'b0;
            sleep_out <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            if (cmd_stb) begin
                cmd_valid <= 1'b1;
                cmd_code  <= stb_byte;
                idx       <= '0;
                state     <= ST_IDLE;
                case (stb_byte)
                    CMD_CASET:   state <= ST_CASET_P;
                    CMD_PASET:   state <= ST_PASET_P;
                    CMD_RAMWR:   state <= ST_RAMWR_HI;
                    CMD_SWRESET: begin
                        disp_on   <= 1'b0;
                        sleep_out <= 1'b0;
                    end
                    CMD_SLPIN:   sleep_out <= 1'b0;
                    CMD_SLPOUT:  sleep_out <= 1'b1;
                    CMD_DISPOFF: disp_on   <= 1'b0;
                    CMD_DISPON:  disp_on   <= 1'b1;
                    default:     state <= ST_SKIP;
                endcase
            end else if (dat_stb) begin
                case (state)
                    ST_CASET_P, ST_PASET_P: begin
                        if (idx < 3'd4) begin
                            idx <= idx + 3'd1;
                            case (idx)
                                3'd0:    p0_lsb <= stb_byte[0];
                                3'd1:    p1     <= stb_byte;
                                3'd2:    p2_lsb <= stb_byte[0];
                                default: ;
                            endcase
                        end
                    end
                    ST_RAMWR_HI: begin
                        hi_byte <= stb_byte;
                        state   <= ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        pix_data  <= to_rgb565(hi_byte, stb_byte);
                        pix_x     <= x;
                        pix_y     <= y;
                        pix_valid <= 1'b1;
                        state     <= ST_RAMWR_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic load_col, load_page, restore, start, advance;

    // Window registers change only when the 4th parameter byte lands.
    assign load_col  = dat_stb && (state == ST_CASET_P) && (idx == 3'd3);
    assign load_page = dat_stb && (state == ST_PASET_P) && (idx == 3'd3);
    assign restore   = cmd_stb && (stb_byte == CMD_SWRESET);
    assign start     = cmd_stb && (stb_byte == CMD_RAMWR);
    assign advance   = dat_stb && (state == ST_RAMWR_LO);

    lcd_addr_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_addr (
        .hwclk     (hwclk),
        .rst       (rst),
        .load_col  (load_col),
        .load_page (load_page),
        .restore   (restore),
        .win_start ({p0_lsb, p1}),
        .win_end   ({p2_lsb, stb_byte}),
        .start     (start),
        .advance   (advance),
        .x         (x),
        .y         (y)
    );

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: drives 8080 bus bytes and checks
// decoded commands, flags and pixel coordinates against hand-computed values.
module tb_lcd_bus_decoder;

    logic        hwclk = 1'b0;
    logic        rst   = 1'b1;
    logic        cmd_valid, pix_valid, disp_on, sleep_out;
    logic [7:0]  cmd_code;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cmd_q[$];
    logic [33:0] pix_q[$];

    lcd_bus_decoder_if bus ();

    lcd_bus_decoder #(.WIDTH(240), .HEIGHT(320)) dut (
        .hwclk     (hwclk),
        .rst       (rst),
        .bus       (bus),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_data  (pix_data),
        .disp_on   (disp_on),
        .sleep_out (sleep_out)
    );

    always #5 hwclk = ~hwclk;

    always @(negedge hwclk) begin
        if (!rst) begin
            if (cmd_valid) cmd_q.push_back(cmd_code);
            if (pix_valid) pix_q.push_back({pix_x, pix_y, pix_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put_byte(input logic is_data, input logic [7:0] b);
        @(posedge hwclk); #1;
        bus.dcx = is_data;
        bus.D   = b;
        bus.wr  = 1'b0;
        repeat (2) @(posedge hwclk);
        #1 bus.wr = 1'b1;
        repeat (2) @(posedge hwclk);
        #1 bus.wr = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] b);
        put_byte(1'b0, b);
    endtask

    task automatic dat(input logic [7:0] b);
        put_byte(1'b1, b);
    endtask

    task automatic pixel(input logic [15:0] v);
        dat(v[15:8]);
        dat(v[7:0]);
    endtask

    task automatic drain();
        repeat (8) @(posedge hwclk);
        #1;
    endtask

    task automatic clear_q();
        cmd_q.delete();
        pix_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, " pix_valid"}, 64'(pix_valid), 64'd0);
        check({tag, " cmd_code"},  64'(cmd_code),  64'd0);
        check({tag, " pix_x"},     64'(pix_x),     64'd0);
        check({tag, " pix_y"},     64'(pix_y),     64'd0);
        check({tag, " pix_data"},  64'(pix_data),  64'd0);
        check({tag, " disp_on"},   64'(disp_on),   64'd0);
        check({tag, " sleep_out"}, 64'(sleep_out), 64'd0);
    endtask

    task automatic check_pix(input string tag, input int i, input logic [8:0] ex,
                             input logic [8:0] ey, input logic [15:0] ed);
        logic [33:0] got;
        got = (i < pix_q.size()) ? pix_q[i] : 34'h3_ffff_ffff;
        check($sformatf("%s[%0d]", tag, i), 64'(got), 64'({ex, ey, ed}));
    endtask

    initial begin
        bus.dcx = 1'b0;
        bus.wr  = 1'b0;
        bus.D   = 8'h00;
        repeat (3) @(posedge hwclk);
        #1 check_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge hwclk);

        // Latency: wr first sampled high at edge k, cmd_valid high after edge k+3.
        #1;
        bus.dcx = 1'b0;
        bus.D   = 8'h28;
        repeat (2) @(posedge hwclk);
        #1 bus.wr = 1'b1;
        repeat (3) @(posedge hwclk);
        #1 check("lat k+2 cmd_valid", 64'(cmd_valid), 64'd0);
        @(posedge hwclk);
        #1 check("lat k+3 cmd_valid", 64'(cmd_valid), 64'd1);
        check("lat cmd_code", 64'(cmd_code), 64'h28);
        bus.wr = 1'b0;
        drain();

        // DISPON, SLPOUT
        clear_q();
        cmd(8'h29);
        cmd(8'h11);
        drain();
        check("flags cmd count", 64'(cmd_q.size()), 64'd2);
        check("flags cmd0", 64'(cmd_q.size() > 0 ? cmd_q[0] : 8'hxx), 64'h29);
        check("flags cmd1", 64'(cmd_q.size() > 1 ? cmd_q[1] : 8'hxx), 64'h11);
        check("flags disp_on", 64'(disp_on), 64'd1);
        check("flags sleep_out", 64'(sleep_out), 64'd1);
        check("flags no pix", 64'(pix_q.size()), 64'd0);

        // 3x2 window at (10..12, 5..6), then a 7th pixel wraps to the start
        clear_q();
        cmd(8'h2A); dat(8'h00); dat(8'h0A); dat(8'h00); dat(8'h0C);
        cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
        cmd(8'h2C);
        for (int i = 0; i < 6; i++) pixel(16'hF800);
        pixel(16'h07E0);
        drain();
        check("win pix count", 64'(pix_q.size()), 64'd7);
        for (int i = 0; i < 6; i++)
            check_pix("win", i, 9'(10 + i % 3), 9'(5 + i / 3), 16'hF800);
        check_pix("wrap", 6, 9'd10, 9'd5, 16'h07E0);

        // Dangling high byte is dropped by a command
        clear_q();
        cmd(8'h2C); dat(8'hAB);
        cmd(8'h00);
        cmd(8'h2C); pixel(16'h1234);
        drain();
        check("abort pix count", 64'(pix_q.size()), 64'd1);
        check_pix("abort", 0, 9'd10, 9'd5, 16'h1234);
        check("abort cmd count", 64'(cmd_q.size()), 64'd3);
        check("abort cmd mid", 64'(cmd_q.size() > 1 ? cmd_q[1] : 8'hxx), 64'h00);

        // Inverted window at the panel corner; 9-bit truncation; 5th byte ignored
        clear_q();
        cmd(8'h2A); dat(8'hFE); dat(8'hEE); dat(8'h00); dat(8'h05); dat(8'hFF);
        cmd(8'h2B); dat(8'h01); dat(8'h3F); dat(8'h00); dat(8'h00);
        cmd(8'h2C);
        pixel(16'h0001); pixel(16'h0002); pixel(16'h0003);
        drain();
        check("edge pix count", 64'(pix_q.size()), 64'd3);
        check_pix("edge", 0, 9'd238, 9'd319, 16'h0001);
        check_pix("edge", 1, 9'd239, 9'd319, 16'h0002);
        check_pix("edge", 2, 9'd238, 9'd319, 16'h0003);

        // SWRESET restores the default window; a partial CASET changes nothing
        clear_q();
        cmd(8'h01);
        drain();
        check("swreset disp_on", 64'(disp_on), 64'd0);
        check("swreset sleep_out", 64'(sleep_out), 64'd0);
        cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00);
        cmd(8'h2C);
        for (int i = 0; i < 16; i++) pixel(16'(16'hA000 + i));
        drain();
        check("partial pix count", 64'(pix_q.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            check_pix("partial", i, 9'(i), 9'd0, 16'(16'hA000 + i));

        // Reset between high and low pixel byte
        cmd(8'h29);
        cmd(8'h2C); dat(8'h55);
        @(posedge hwclk); #1 rst = 1'b1;
        @(posedge hwclk);
        #1 check_zero("midreset");
        rst = 1'b0;
        clear_q();
        dat(8'h66);
        drain();
        check("midreset no pix", 64'(pix_q.size()), 64'd0);
        check("midreset no cmd", 64'(cmd_q.size()), 64'd0);
        cmd(8'h2C); pixel(16'hBEEF);
        drain();
        check("post reset pix count", 64'(pix_q.size()), 64'd1);
        check_pix("post reset", 0, 9'd0, 9'd0, 16'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
